// File: rtl/ibis_tmds_scheduler.sv
// ----------------------------------------------------------------------------
// ibis_tmds_scheduler
//
// Feeds three external 10:1 TMDS serializers with pre-encoded 10-bit words.
// Words arrive through a small FIFO. After a programmable start-up wait, one
// word per channel is launched every five aclk cycles. Each launch takes the
// FIFO head, or DVI control tokens when the FIFO is empty. The serializer
// samples pump_data* during phase 0.
//
// Optional feature:
//   IBIS_TMDS_SCHED_UNDERFLOW_CNT_EN  - when defined, build the saturating
//   underflow counter. Otherwise underflow_count is tied to zero.
//
// Ports:
//   aclk, aresetn     clock, asynchronous active-low reset
//   start             level, leave IDLE and begin the start-up wait
//   stop              level, return to IDLE (at the next symbol boundary in RUN)
//   frame_active      host marks active video (token launches count as underflow)
//   sync[1:0]         {vsync,hsync}, selects the control token for channel 0
//   s_valid/s_ready   word handshake into the FIFO
//   s_data[29:0]      {ch2,ch1,ch0} pre-encoded TMDS words
//   pump_resetn       active-low serializer reset (low only in IDLE)
//   pump_enable       serializer enable (high only in RUN)
//   pump_data0/1/2    parallel word per channel, reloaded once per symbol
//   underflow_count   saturating count of token launches during active video
//   running           high while in RUN
// ----------------------------------------------------------------------------
module ibis_tmds_scheduler #(
    parameter int unsigned STARTUP_CYCLES = 1024,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic        stop,
    input  logic        frame_active,
    input  logic [1:0]  sync,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [29:0] s_data,
    output logic        pump_resetn,
    output logic        pump_enable,
    output logic [9:0]  pump_data0,
    output logic [9:0]  pump_data1,
    output logic [9:0]  pump_data2,
    output logic [15:0] underflow_count,
    output logic        running
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]  FIFO_FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0]  WAIT_LAST     = 16'(STARTUP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] wait_cnt;
    logic [2:0]  phase;
    logic        stop_pend;

    // FIFO storage and bookkeeping
    logic [29:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic [AW:0]   fifo_cnt_nxt;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    // Output-decode results, registered below
    logic load;
    logic pump_resetn_nxt;
    logic pump_enable_nxt;
    logic running_nxt;

    // DVI control-period token for a given {vsync,hsync}
    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        case (c)
            2'b00:   ctrl_token = 10'b1101010100;
            2'b01:   ctrl_token = 10'b0010101011;
            2'b10:   ctrl_token = 10'b0101010100;
            default: ctrl_token = 10'b1010101011;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned
        // (which would infer a latch).
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (stop)                       state_nxt = ST_IDLE;
                else if (wait_cnt == WAIT_LAST) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // Leave only at a symbol boundary; an earlier stop is remembered.
                if (phase == 3'd4 && (stop || stop_pend)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output decode (next values of the registered outputs)
    // ------------------------------------------------------------------------
    always_comb begin
        pump_resetn_nxt = (state_nxt != ST_IDLE);
        pump_enable_nxt = (state_nxt == ST_RUN);
        running_nxt     = (state_nxt == ST_RUN);
        // Launch on RUN entry and at every phase-4 -> phase-0 boundary that
        // stays in RUN, so the word is stable through phase 0.
        load = (state == ST_WAIT && state_nxt == ST_RUN) ||
               (state == ST_RUN  && state_nxt == ST_RUN && phase == 3'd4);
    end

    // ------------------------------------------------------------------------
    // Start-up wait counter, symbol phase and pending stop
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wait_cnt  <= '0;
            phase     <= '0;
            stop_pend <= 1'b0;
        end else begin
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 16'd1 : 16'd0;

            if (state == ST_RUN && state_nxt == ST_RUN) begin
                phase     <= (phase == 3'd4) ? 3'd0 : phase + 3'd1;
                stop_pend <= stop_pend | stop;
            end else begin
                phase     <= '0;
                stop_pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------------
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = s_valid & s_ready;
    assign pop        = load & ~fifo_empty;

    always_comb begin
        fifo_cnt_nxt = fifo_cnt;
        if (push && !pop)      fifo_cnt_nxt = fifo_cnt + 1'b1;
        else if (pop && !push) fifo_cnt_nxt = fifo_cnt - 1'b1;
    end

    // NOTE: the storage array has no reset; resetting the pointers and count
    // is what empties the FIFO, and it keeps the array mappable to RAM.
    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            s_ready  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt_nxt;
            // Registered ready tracks the post-edge occupancy, so a slot freed
            // by a pop is offered on the following cycle (no full bypass).
            s_ready  <= (fifo_cnt_nxt != FIFO_FULL_CNT);
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pump_resetn <= 1'b0;
            pump_enable <= 1'b0;
            running     <= 1'b0;
            pump_data0  <= '0;
            pump_data1  <= '0;
            pump_data2  <= '0;
        end else begin
            pump_resetn <= pump_resetn_nxt;
            pump_enable <= pump_enable_nxt;
            running     <= running_nxt;
            if (load) begin
                if (!fifo_empty) begin
                    {pump_data2, pump_data1, pump_data0} <= mem[rd_ptr];
                end else begin
                    pump_data0 <= ctrl_token(sync);
                    pump_data1 <= ctrl_token(2'b00);
                    pump_data2 <= ctrl_token(2'b00);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Underflow counter
    // ------------------------------------------------------------------------
`ifdef IBIS_TMDS_SCHED_UNDERFLOW_CNT_EN
    logic [15:0] underflow_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            underflow_q <= '0;
        end else if (load && fifo_empty && frame_active && underflow_q != 16'hFFFF) begin
            underflow_q <= underflow_q + 16'd1;
        end
    end

    assign underflow_count = underflow_q;
`else
    logic unused_frame_active;
    assign unused_frame_active = frame_active;
    assign underflow_count     = 16'h0000;
`endif

endmodule

// File: tb/tb_ibis_tmds_scheduler.sv
// ----------------------------------------------------------------------------
// tb_ibis_tmds_scheduler
//
// Directed bench for ibis_tmds_scheduler with STARTUP_CYCLES=8, FIFO_DEPTH=4.
// Inputs change 1 time unit after the rising edge. Outputs are sampled there
// too, well away from the next edge.
// ----------------------------------------------------------------------------
module tb_ibis_tmds_scheduler;

    localparam int unsigned STARTUP = 8;

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_10 = 10'b0101010100;

`ifdef IBIS_TMDS_SCHED_UNDERFLOW_CNT_EN
    localparam logic [15:0] UF_EXP = 16'd3;
`else
    localparam logic [15:0] UF_EXP = 16'd0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        start;
    logic        stop;
    logic        frame_active;
    logic [1:0]  sync;
    logic        s_valid;
    logic        s_ready;
    logic [29:0] s_data;
    logic        pump_resetn;
    logic        pump_enable;
    logic [9:0]  pump_data0;
    logic [9:0]  pump_data1;
    logic [9:0]  pump_data2;
    logic [15:0] underflow_count;
    logic        running;

    int checks = 0;
    int errors = 0;

    ibis_tmds_scheduler #(
        .STARTUP_CYCLES (STARTUP),
        .FIFO_DEPTH     (4)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .start           (start),
        .stop            (stop),
        .frame_active    (frame_active),
        .sync            (sync),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .pump_resetn     (pump_resetn),
        .pump_enable     (pump_enable),
        .pump_data0      (pump_data0),
        .pump_data1      (pump_data1),
        .pump_data2      (pump_data2),
        .underflow_count (underflow_count),
        .running         (running)
    );

    always #5 aclk = ~aclk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Distinct words: {ch2,ch1,ch0}
    logic [29:0] word_a, word_b, word_c;

    initial begin
        word_a = {10'h3A1, 10'h2B2, 10'h1C3};
        word_b = {10'h0F4, 10'h1E5, 10'h2D6};
        word_c = {10'h137, 10'h248, 10'h359};

        aresetn      = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        frame_active = 1'b0;
        sync         = 2'b10;
        s_valid      = 1'b0;
        s_data       = '0;

        // ---- reset state ----
        tick(2);
        check("rst_s_ready",     32'(s_ready),         32'd0);
        check("rst_pump_resetn", 32'(pump_resetn),     32'd0);
        check("rst_pump_enable", 32'(pump_enable),     32'd0);
        check("rst_running",     32'(running),         32'd0);
        check("rst_pump_data0",  32'(pump_data0),      32'd0);
        check("rst_underflow",   32'(underflow_count), 32'd0);

        aresetn = 1'b1;
        tick();
        check("ready_after_rst", 32'(s_ready), 32'd1);

        // ---- push A,B,C while idle ----
        s_valid = 1'b1;
        s_data  = word_a; tick();
        s_data  = word_b; tick();
        s_data  = word_c; tick();
        s_valid = 1'b0;
        check("ready_after_3", 32'(s_ready), 32'd1);
        check("idle_enable",   32'(pump_enable), 32'd0);

        // ---- start: WAIT for 8 cycles then RUN ----
        start = 1'b1; tick(); start = 1'b0;
        check("wait_resetn",  32'(pump_resetn), 32'd1);
        check("wait_enable",  32'(pump_enable), 32'd0);
        tick(STARTUP - 1);
        check("wait7_enable", 32'(pump_enable), 32'd0);
        tick();
        check("run_enable",   32'(pump_enable), 32'd1);
        check("run_running",  32'(running),     32'd1);
        check("load_a_ch0",   32'(pump_data0),  32'(word_a[9:0]));
        check("load_a_ch1",   32'(pump_data1),  32'(word_a[19:10]));
        check("load_a_ch2",   32'(pump_data2),  32'(word_a[29:20]));

        // Word holds through phases 1..4, next load at the phase-4 edge
        tick(4);
        check("hold_a_ph4",   32'(pump_data0),  32'(word_a[9:0]));
        tick();
        check("load_b_ch0",   32'(pump_data0),  32'(word_b[9:0]));
        check("load_b_ch2",   32'(pump_data2),  32'(word_b[29:20]));
        tick(5);
        check("load_c_ch0",   32'(pump_data0),  32'(word_c[9:0]));
        check("load_c_ch1",   32'(pump_data1),  32'(word_c[19:10]));

        // FIFO empty: control tokens for sync=2'b10
        tick(5);
        check("tok_ch0",      32'(pump_data0),  32'(TOK_10));
        check("tok_ch1",      32'(pump_data1),  32'(TOK_00));
        check("tok_ch2",      32'(pump_data2),  32'(TOK_00));
        check("uf_inactive",  32'(underflow_count), 32'd0);

        // ---- underflow: three token loads during active video ----
        frame_active = 1'b1;
        tick(15);
        check("uf_three",     32'(underflow_count), 32'(UF_EXP));
`ifdef IBIS_TMDS_SCHED_UNDERFLOW_CNT_EN
        force dut.underflow_q = 16'hFFFF;
        #1;
        release dut.underflow_q;
        tick(5);
        check("uf_saturate",  32'(underflow_count), 32'h0000FFFF);
`endif
        frame_active = 1'b0;

        // ---- stop in phase 1: held until phase 4 completes ----
        tick();                              // now in phase 1
        stop = 1'b1; tick(); stop = 1'b0;    // now phase 2, stop pending
        check("stop_ph2_enable", 32'(pump_enable), 32'd1);
        tick(2);                             // phase 4
        check("stop_ph4_enable", 32'(pump_enable), 32'd1);
        tick();
        check("stop_idle_enable",  32'(pump_enable), 32'd0);
        check("stop_idle_running", 32'(running),     32'd0);
        check("stop_idle_resetn",  32'(pump_resetn), 32'd0);
        tick(3);
        check("idle_data_hold",    32'(pump_data0),  32'(TOK_10));

        // ---- fill FIFO with continuous s_valid ----
        s_valid = 1'b1;
        s_data = {10'h301, 10'h201, 10'h101}; tick();
        s_data = {10'h302, 10'h202, 10'h102}; tick();
        s_data = {10'h303, 10'h203, 10'h103}; tick();
        check("fill3_ready", 32'(s_ready), 32'd1);
        s_data = {10'h304, 10'h204, 10'h104}; tick();
        check("fill4_ready", 32'(s_ready), 32'd0);
        s_data = {10'h305, 10'h205, 10'h105}; tick(2);
        check("full_ready",  32'(s_ready), 32'd0);
        s_valid = 1'b0;

        // ---- restart: phase realigned to 0 at RUN entry ----
        start = 1'b1; tick(); start = 1'b0;
        tick(STARTUP);
        check("rerun_enable",  32'(pump_enable), 32'd1);
        check("rerun_d0",      32'(pump_data0),  32'h101);
        check("rerun_ready",   32'(s_ready),     32'd1);
        tick(5);
        check("rerun_d1",      32'(pump_data0),  32'h102);

        // ---- asynchronous reset mid-RUN with a pending stop ----
        tick();                              // phase 1
        stop = 1'b1; tick(); stop = 1'b0;    // stop pending
        aresetn = 1'b0;
        #2;
        check("mid_rst_ready",   32'(s_ready),         32'd0);
        check("mid_rst_resetn",  32'(pump_resetn),     32'd0);
        check("mid_rst_enable",  32'(pump_enable),     32'd0);
        check("mid_rst_running", 32'(running),         32'd0);
        check("mid_rst_data",    32'({pump_data2, pump_data1, pump_data0}), 32'd0);
        check("mid_rst_uf",      32'(underflow_count), 32'd0);
        tick();
        aresetn = 1'b1;
        tick();
        check("mid_rst_ready1",  32'(s_ready), 32'd1);

        // FIFO contents and pending stop were discarded
        start = 1'b1; tick(); start = 1'b0;
        tick(STARTUP);
        check("post_rst_run",    32'(running),    32'd1);
        check("post_rst_tok",    32'(pump_data0), 32'(TOK_10));
        tick(6);
        check("post_rst_nostop", 32'(running),    32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
